// File: rtl/seg_readback_decoder.sv
// ============================================================================
//  Module      : seg_readback_decoder
//  Description : Recovers the 24-bit hex value shown on a six-digit
//                seven-segment bus, with glitch filtering and digit flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_readback_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      segments_i,
    output logic [23:0]      value_o,
    output logic [5:0]       digit_err_o,
    output logic [5:0]       digit_blank_o,
    output logic             update_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] commit_count_o
);

    localparam logic [7:0] c_RUN_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_RUN_LAST = 8'(STABLE_CYCLES - 1);

    localparam logic [1:0] c_ST_EMPTY  = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;

    logic [47:0]      seg_q,   seg_d;
    logic [47:0]      pat_q,   pat_d;
    logic [7:0]       run_q,   run_d;
    logic [1:0]       state_q, state_d;
    logic [23:0]      value_q, value_d;
    logic [5:0]       err_q,   err_d;
    logic [5:0]       blank_q, blank_d;
    logic             upd_q,   upd_d;
    logic             lock_q,  lock_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [23:0] w_val;
    logic [5:0]  w_err;
    logic [5:0]  w_blank;
    logic        w_same;
    logic        w_run_hit;
    logic        w_commit;

    // Returns {legal, nibble}; illegal patterns yield a zero nibble.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        logic [4:0] w_dec;
        assign w_dec              = seg_to_hex(seg_q[8*gi +: 7]);
        assign w_blank[gi]        = (seg_q[8*gi +: 7] == 7'h7F);
        assign w_err[gi]          = (!w_dec[4] && !w_blank[gi]) || !seg_q[8*gi + 7];
        assign w_val[4*gi +: 4]   = w_dec[3:0];
    end

    assign w_same    = (segments_i == seg_q);
    assign w_run_hit = (run_q == c_RUN_LAST);
    assign w_commit  = w_same && w_run_hit &&
                       ((state_q == c_ST_EMPTY) || (seg_q != pat_q));

    always_comb begin
        seg_d   = segments_i;
        pat_d   = pat_q;
        state_d = state_q;
        value_d = value_q;
        err_d   = err_q;
        blank_d = blank_q;
        upd_d   = 1'b0;
        lock_d  = lock_q;
        cnt_d   = cnt_q;

        // Run saturates at the window length so a held pattern fires once.
        if (!w_same) begin
            run_d = 8'd0;
        end else if (run_q == c_RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 8'd1;
        end

        if (w_commit) begin
            value_d = w_val;
            err_d   = w_err;
            blank_d = w_blank;
            pat_d   = seg_q;
            upd_d   = 1'b1;
            lock_d  = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = c_ST_HOLD;
        end else begin
            case (state_q)
                c_ST_EMPTY:  state_d = c_ST_EMPTY;
                c_ST_HOLD: begin
                    if (segments_i != pat_q) begin
                        state_d = c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    // Settled back on the committed pattern: silent return.
                    if (w_same && w_run_hit && (seg_q == pat_q)) begin
                        state_d = c_ST_HOLD;
                    end
                end
                default:     state_d = c_ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= '0;
            pat_q   <= '0;
            run_q   <= '0;
            state_q <= c_ST_EMPTY;
            value_q <= '0;
            err_q   <= '0;
            blank_q <= '0;
            upd_q   <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            seg_q   <= seg_d;
            pat_q   <= pat_d;
            run_q   <= run_d;
            state_q <= state_d;
            value_q <= value_d;
            err_q   <= err_d;
            blank_q <= blank_d;
            upd_q   <= upd_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign value_o        = value_q;
    assign digit_err_o    = err_q;
    assign digit_blank_o  = blank_q;
    assign update_o       = upd_q;
    assign locked_o       = lock_q;
    assign commit_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_readback_decoder.sv
// ============================================================================
//  Module      : tb_seg_readback_decoder
//  Description : Self-checking bench for seg_readback_decoder (two configs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_readback_decoder;

    localparam int S0 = 4;
    localparam int C0 = 16;
    localparam int S1 = 1;
    localparam int C1 = 4;

    localparam logic [6:0] PAT_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] seg   = '0;

    logic [23:0] val0, val1;
    logic [5:0]  err0, err1, blk0, blk1;
    logic        upd0, upd1, lck0, lck1;
    logic [C0-1:0] cnt0;
    logic [C1-1:0] cnt1;

    seg_readback_decoder #(.STABLE_CYCLES(S0), .CNT_W(C0)) dut (
        .clk(clk), .rst_n(rst_n), .segments_i(seg),
        .value_o(val0), .digit_err_o(err0), .digit_blank_o(blk0),
        .update_o(upd0), .locked_o(lck0), .commit_count_o(cnt0)
    );

    seg_readback_decoder #(.STABLE_CYCLES(S1), .CNT_W(C1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .segments_i(seg),
        .value_o(val1), .digit_err_o(err1), .digit_blank_o(blk1),
        .update_o(upd1), .locked_o(lck1), .commit_count_o(cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sample history plus per-config committed state.
    logic [47:0] hist [$];
    int          m_S   [2] = '{S0, S1};
    int          m_max [2] = '{(1 << C0) - 1, (1 << C1) - 1};
    logic [23:0] m_val [2];
    logic [5:0]  m_err [2];
    logic [5:0]  m_blk [2];
    logic        m_upd [2];
    logic        m_lck [2];
    int          m_cnt [2];
    logic [47:0] m_pat [2];

    function automatic logic [5:0] ref_digit(input logic [7:0] b);
        logic [3:0] nib   = 4'h0;
        logic       legal = 1'b0;
        logic       blank;
        for (int v = 0; v < 16; v++) begin
            if (PAT_TAB[v] == b[6:0]) begin
                nib   = 4'(v);
                legal = 1'b1;
            end
        end
        blank = (b[6:0] == 7'h7F);
        return {(!legal && !blank) || !b[7], blank, nib};
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(48'h0);
        for (int i = 0; i < 2; i++) begin
            m_val[i] = '0; m_err[i] = '0; m_blk[i] = '0;
            m_upd[i] = 1'b0; m_lck[i] = 1'b0; m_cnt[i] = 0; m_pat[i] = '0;
        end
    endtask

    task automatic model_edge(input logic [47:0] x);
        int tr;
        int j;
        logic [5:0] r;
        hist.push_back(x);
        if (hist.size() > 300) void'(hist.pop_front());
        tr = 0;
        j  = hist.size() - 1;
        while (j >= 0) begin
            if (hist[j] != x) break;
            tr++;
            j--;
        end
        for (int i = 0; i < 2; i++) begin
            m_upd[i] = 1'b0;
            if (tr == m_S[i] + 1 && (!m_lck[i] || x != m_pat[i])) begin
                for (int d = 0; d < 6; d++) begin
                    r = ref_digit(x[8*d +: 8]);
                    m_val[i][4*d +: 4] = r[3:0];
                    m_blk[i][d]        = r[4];
                    m_err[i][d]        = r[5];
                end
                m_pat[i] = x;
                m_upd[i] = 1'b1;
                m_lck[i] = 1'b1;
                if (m_cnt[i] < m_max[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("d0 value",  48'(val0), 48'(m_val[0]));
        check("d0 err",    48'(err0), 48'(m_err[0]));
        check("d0 blank",  48'(blk0), 48'(m_blk[0]));
        check("d0 update", 48'(upd0), 48'(m_upd[0]));
        check("d0 locked", 48'(lck0), 48'(m_lck[0]));
        check("d0 count",  48'(cnt0), 48'(m_cnt[0]));
        check("d1 value",  48'(val1), 48'(m_val[1]));
        check("d1 err",    48'(err1), 48'(m_err[1]));
        check("d1 blank",  48'(blk1), 48'(m_blk[1]));
        check("d1 update", 48'(upd1), 48'(m_upd[1]));
        check("d1 locked", 48'(lck1), 48'(m_lck[1]));
        check("d1 count",  48'(cnt1), 48'(m_cnt[1]));
    endtask

    task automatic step(input logic [47:0] x);
        seg = x;
        @(posedge clk);
        model_edge(x);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " value"},  48'(val0), 48'h0);
        check({tag, " err"},    48'(err0), 48'h0);
        check({tag, " blank"},  48'(blk0), 48'h0);
        check({tag, " update"}, 48'(upd0), 48'h0);
        check({tag, " locked"}, 48'(lck0), 48'h0);
        check({tag, " count"},  48'(cnt0), 48'h0);
        check({tag, " count1"}, 48'(cnt1), 48'h0);
    endtask

    function automatic logic [47:0] rand_pattern();
        logic [47:0] p;
        int r;
        for (int d = 0; d < 6; d++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       p[8*d +: 8] = {1'b1, PAT_TAB[$urandom_range(0, 15)]};
            else if (r == 6) p[8*d +: 8] = 8'hFF;
            else if (r == 7) p[8*d +: 8] = {1'b0, PAT_TAB[$urandom_range(0, 15)]};
            else             p[8*d +: 8] = 8'($urandom);
        end
        return p;
    endfunction

    typedef struct {
        logic [47:0] seg;
        logic [23:0] val;
        logic [5:0]  err;
        logic [5:0]  blank;
    } vec_t;

    vec_t vecs [5];

    localparam logic [47:0] P1 = 48'hF9A4_B099_9282;

    initial begin
        logic [47:0] pa, pb, pr, prev, cur;
        logic [23:0] v_before;
        int          c_before;
        int          hold;

        vecs[0] = '{48'hF9A4_B099_9282, 24'h123456, 6'h00, 6'h00};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 24'h000000, 6'h00, 6'h3F};
        vecs[2] = '{48'hC0C0_C0C0_407E, 24'h000000, 6'h03, 6'h00};
        vecs[3] = '{48'h8E86_A1C6_8388, 24'hFEDCBA, 6'h00, 6'h00};
        vecs[4] = '{48'h7990_F8FF_0012, 24'h197085, 6'h23, 6'h04};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First commit lands exactly STABLE_CYCLES edges after the first sample.
        for (int e = 1; e <= 6; e++) begin
            step(P1);
            check("latency update", 48'(upd0), 48'(e == 5));
        end
        check("first count",  48'(cnt0), 48'h1);
        check("first locked", 48'(lck0), 48'h1);

        for (int v = 0; v < 5; v++) begin
            repeat (7) step(vecs[v].seg);
            check("vec value", 48'(val0), 48'(vecs[v].val));
            check("vec err",   48'(err0), 48'(vecs[v].err));
            check("vec blank", 48'(blk0), 48'(vecs[v].blank));
            check("vec s1 value", 48'(val1), 48'(vecs[v].val));
        end
        check("table count", 48'(cnt0), 48'h5);

        // Toggling faster than the window never commits.
        pa = 48'hC0C0_C0C0_C0F9;
        pb = 48'hC0C0_C0C0_C0A4;
        v_before = val0;
        c_before = int'(cnt0);
        for (int c = 0; c < 40; c++) begin
            step(((c / 2) % 2) != 0 ? pa : pb);
            check("toggle update", 48'(upd0), 48'h0);
        end
        check("toggle count", 48'(cnt0), 48'(c_before));
        check("toggle value", 48'(val0), 48'(v_before));

        // Glitch away and back to the committed pattern: silent.
        repeat (6) step(P1);
        c_before = int'(cnt0);
        step(pa);
        for (int c = 0; c < 8; c++) begin
            step(P1);
            check("glitch update", 48'(upd0), 48'h0);
        end
        check("glitch count", 48'(cnt0), 48'(c_before));

        // Reset mid-settle discards progress; a full window is required again.
        pr = vecs[4].seg;
        step(pr);
        step(pr);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step(pr);
            check("post-reset update", 48'(upd0), 48'(e == 5));
        end

        // Randomized traffic, including returns to earlier patterns.
        prev = P1;
        cur  = P1;
        for (int n = 0; n < 120; n++) begin
            logic [47:0] nxt;
            if ($urandom_range(0, 3) == 0) nxt = prev;
            else                           nxt = rand_pattern();
            prev = cur;
            cur  = nxt;
            hold = $urandom_range(1, 7);
            repeat (hold) step(cur);
        end

        // Counter saturation on the 4-bit, single-cycle-window instance.
        for (int k = 0; k < 18; k++) begin
            cur = 48'hC0C0_C0C0_C000 | 48'(k + 1);
            step(cur);
            step(cur);
            check("sat update", 48'(upd1), 48'h1);
        end
        check("sat count", 48'(cnt1), 48'hF);
        step(cur);
        check("sat update low", 48'(upd1), 48'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_readback_decoder.md
Name: seg_readback_decoder

Overview:
- Inverse of the display encoder path: takes the 48-bit six-digit seven-segment bus and reconstructs the 24-bit hex value.
- Filters glitches with a stability window, flags illegal and blank digit patterns, and emits a one-cycle update pulse when a new stable pattern is committed.
- Used for display loopback self-check and debug readback of what the board displays.

Parameters:
- STABLE_CYCLES, 4: consecutive matching samples required before commit; legal range 1..255.
- CNT_W, 16: width of the saturating commit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- segments  input  48  six 8-bit digit fields, digit i at [8i+7:8i]; bits [6:0] = g..a active-low; bit 7 = dp, active-low, must be 1.
- value  output  24  committed hex value; digit i at [4i+3:4i].
- digit_err  output  6  per-digit flag: pattern not in the legal set, or dp bit low.
- digit_blank  output  6  per-digit flag: pattern 0x7F (all segments off).
- update  output  1  one-cycle pulse on each commit.
- locked  output  1  high once at least one commit has occurred since reset.
- commit_count  output  CNT_W  number of commits since reset; saturates at all-ones.

Behaviour:
- Legal digit patterns, bits [6:0]: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Any other pattern except 7F: digit_err set, value nibble 0.
- 7F: digit_blank set, digit_err clear, value nibble 0.
- dp bit 0: digit_err set; the nibble is still decoded from bits [6:0].
- Reset, asynchronous: value=0, digit_err=0, digit_blank=0, update=0, locked=0, commit_count=0. Internal state cleared: seg_q=0, run=0, committed pattern invalid, FSM=EMPTY.
- Reset asserted mid-settle discards all progress. After release, a full window is required again.
- Sampling:
  - Every edge: seg_q <= segments.
  - If segments == seg_q, run <= min(run+1, STABLE_CYCLES); otherwise run <= 0.
- Commit condition, evaluated at an edge: segments == seg_q, run == STABLE_CYCLES-1, and (FSM==EMPTY or seg_q != committed pattern).
- At a commit edge:
  - value, digit_err and digit_blank are loaded from the decode of seg_q.
  - The committed pattern is set to seg_q.
  - update <= 1; locked <= 1; commit_count increments (saturating).
- update is 0 at every edge that is not a commit edge.
- Latency: if the input first lands in seg_q at edge k and is held, the commit happens at edge k+STABLE_CYCLES. update is high for exactly the following cycle.
- FSM states:
  - EMPTY: nothing committed. Goes to HOLD on a commit.
  - HOLD: the input equals the committed pattern. Goes to SETTLE when segments != committed pattern.
  - SETTLE: the input differs from the committed pattern. Goes to HOLD on a commit, or when the input returns to the committed pattern and is held for the full window; the return case produces no commit and no update.
- Re-presenting the already-committed pattern never re-commits, even after a glitch.
- Input toggling faster than the window: run keeps resetting; no commit; outputs hold.
- Once saturated at STABLE_CYCLES, run stays there while the input is stable, so no repeat commit occurs.
- STABLE_CYCLES=1: commit on the first edge where segments == seg_q.
- Outputs are registered only; there is no combinational path from segments to any output.

Test Plan:
- Reset, then hold segments=48'hF9A4_B099_9282 (STABLE_CYCLES=4) -> exactly 4 edges after first sample: value=24'h123456, digit_err=0, digit_blank=0, one update pulse, locked=1, commit_count=1.
- Hold 48'hF9A4_B099_9282, then present 48'hFFFF_FFFF_FFFF -> commit with value=0, digit_blank=6'h3F, digit_err=0, commit_count=2.
- Present digit0 byte 0x7E (illegal) plus digit1 byte 0x40 (dp low, '0'), others 0xC0 -> digit_err=6'h03, value=0, digit_blank=0.
- Alternate two patterns every 2 cycles for 40 cycles (STABLE_CYCLES=4) -> update never asserts; value, digit flags and commit_count unchanged.
- After committing pattern P, glitch 1 cycle to Q, then return to P and hold -> no update and no count change. Then assert rst_n=0 mid-settle of a new pattern -> all outputs 0 immediately; after release, commit requires a full new window.
- Force commit_count near saturation (CNT_W=4, 16 distinct commits) -> count stays 4'hF; update still pulses on each commit.
